// File: rtl/pixel_linebuf.sv
// Pixel line buffer: streams 8-pixel groups, pairs each with the group
// directly above it from the previous line, and flushes two zero beats
// at the end of every frame.
module pixel_linebuf (
  input  logic        clk,
  input  logic        rstn,
  input  logic [9:0]  width,
  input  logic [15:0] height,
  input  logic        start,
  input  logic        i_vl,
  input  logic [7:0]  i_x [1:8],
  output logic        o_rdy,
  output logic        o_ena,
  output logic [7:0]  o_b [1:8],
  output logic [7:0]  o_x [1:8],
  output logic        o_done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t      state;
  logic [9:0]  width_r;
  logic [15:0] height_r;
  logic [9:0]  hpos;
  logic [15:0] vpos;
  logic        flush_cnt;
  logic        accept;
  logic        last_beat;
  logic [63:0] line_in;
  logic [7:0]  rd_lane [1:8];
  logic [63:0] mem [0:1023];

  assign o_rdy     = (state == RUN);
  assign accept    = i_vl && o_rdy;
  assign last_beat = (hpos == width_r) && (vpos == height_r - 16'd1);

  // Pack the incoming group (lane 1 in the top byte) and split the stored word back into lanes
  always_comb begin
    line_in = '0;
    for (int i = 1; i <= 8; i++) begin
      line_in[(8-i)*8 +: 8] = i_x[i];
      rd_lane[i]            = mem[hpos][(8-i)*8 +: 8];
    end
  end

  // Line memory: write-only here, so the control block sees pre-write contents
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[hpos] <= line_in;
    end
  end

  // Frame FSM, position counters and registered output datapath
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      width_r   <= '0;
      height_r  <= '0;
      hpos      <= '0;
      vpos      <= '0;
      flush_cnt <= 1'b0;
      o_ena     <= 1'b0;
      o_done    <= 1'b0;
      for (int i = 1; i <= 8; i++) begin
        o_x[i] <= '0;
        o_b[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          o_ena  <= 1'b0;
          o_done <= 1'b0;
          if (start) begin
            width_r  <= width;
            height_r <= height;
            hpos     <= '0;
            vpos     <= '0;
            state    <= (height != 16'd0) ? RUN : DONE;
          end
        end
        RUN: begin
          o_ena <= accept;
          if (accept) begin
            for (int i = 1; i <= 8; i++) begin
              o_x[i] <= i_x[i];
              o_b[i] <= (vpos == 16'd0) ? 8'd0 : rd_lane[i];
            end
            if (hpos == width_r) begin
              hpos <= '0;
              vpos <= vpos + 16'd1;
            end else begin
              hpos <= hpos + 10'd1;
            end
            if (last_beat) begin
              flush_cnt <= 1'b0;
              state     <= FLUSH;
            end
          end
        end
        FLUSH: begin
          o_ena     <= 1'b1;
          flush_cnt <= 1'b1;
          for (int i = 1; i <= 8; i++) begin
            o_x[i] <= '0;
            o_b[i] <= '0;
          end
          if (flush_cnt) begin
            state <= DONE;
          end
        end
        DONE: begin
          o_ena  <= 1'b0;
          o_done <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_linebuf.sv
// Directed, table-driven bench for pixel_linebuf.
module tb_pixel_linebuf;

  typedef struct {
    logic [63:0] px;
    logic        vl;
    logic        st;
    logic [63:0] ex;
    logic [63:0] eb;
  } vec_t;

  typedef struct {
    logic [63:0] x;
    logic [63:0] b;
    int          c;
  } obs_t;

  logic        clk;
  logic        rstn;
  logic [9:0]  width;
  logic [15:0] height;
  logic        start;
  logic        i_vl;
  logic [7:0]  i_x [1:8];
  logic        o_rdy;
  logic        o_ena;
  logic [7:0]  o_b [1:8];
  logic [7:0]  o_x [1:8];
  logic        o_done;

  logic [63:0] ox_p;
  logic [63:0] ob_p;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   st_cyc = 0;
  logic rdy_seen = 1'b0;
  obs_t outq [$];
  vec_t vecs [$];

  pixel_linebuf dut (
    .clk    (clk),
    .rstn   (rstn),
    .width  (width),
    .height (height),
    .start  (start),
    .i_vl   (i_vl),
    .i_x    (i_x),
    .o_rdy  (o_rdy),
    .o_ena  (o_ena),
    .o_b    (o_b),
    .o_x    (o_x),
    .o_done (o_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  always_comb begin
    ox_p = '0;
    ob_p = '0;
    for (int i = 1; i <= 8; i++) begin
      ox_p[(8-i)*8 +: 8] = o_x[i];
      ob_p[(8-i)*8 +: 8] = o_b[i];
    end
  end

  // Record every emitted group, every done pulse and any ready assertion
  always @(negedge clk) begin
    obs_t o;
    if (o_ena) begin
      o.x = ox_p;
      o.b = ob_p;
      o.c = cyc;
      outq.push_back(o);
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (o_rdy) rdy_seen = 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive_x(input logic [63:0] px);
    for (int i = 1; i <= 8; i++) i_x[i] = px[(8-i)*8 +: 8];
  endtask

  function automatic vec_t mk(input logic [63:0] px, input logic vl, input logic st,
                              input logic [63:0] ex, input logic [63:0] eb);
    vec_t v;
    v.px = px; v.vl = vl; v.st = st; v.ex = ex; v.eb = eb;
    return v;
  endfunction

  task automatic start_frame(input logic [9:0] w, input logic [15:0] h);
    width  = w;
    height = h;
    start  = 1'b1;
    st_cyc = cyc;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int d0, input int limit);
    int n;
    n = 0;
    while (done_cnt == d0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(nm, (done_cnt != d0), 1);
  endtask

  // Start a frame, play the vector table, then compare every emitted group and the frame tail
  task automatic applyStimulus(input string nm, input logic [9:0] w, input logic [15:0] h);
    int   d0;
    int   nexp;
    int   exp_c [$];
    vec_t ev [$];
    outq.delete();
    d0 = done_cnt;
    start_frame(w, h);
    chk({nm, "_rdy"}, o_rdy, 1);
    foreach (vecs[k]) begin
      i_vl = vecs[k].vl;
      drive_x(vecs[k].px);
      if (vecs[k].st) begin
        start  = 1'b1;
        width  = 10'd0;
        height = 16'd1;
      end else begin
        start = 1'b0;
      end
      if (vecs[k].vl) begin
        ev.push_back(vecs[k]);
        exp_c.push_back(cyc + 1);
      end
      @(negedge clk);
    end
    i_vl  = 1'b0;
    start = 1'b0;
    wait_done({nm, "_done_seen"}, d0, 60);
    repeat (3) @(negedge clk);
    checkOutput(nm, ev, exp_c, d0);
  endtask

  task automatic checkOutput(input string nm, input vec_t ev [$], input int exp_c [$], input int d0);
    int nexp;
    int lc;
    nexp = ev.size();
    chk({nm, "_count"}, outq.size(), nexp + 2);
    for (int k = 0; k < nexp && k < outq.size(); k++) begin
      chk($sformatf("%s_x%0d", nm, k), outq[k].x, ev[k].ex);
      chk($sformatf("%s_b%0d", nm, k), outq[k].b, ev[k].eb);
      chk($sformatf("%s_cyc%0d", nm, k), outq[k].c, exp_c[k]);
    end
    if (outq.size() == nexp + 2) begin
      lc = exp_c[nexp-1];
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("%s_flush_x%0d", nm, k), outq[nexp+k].x, 0);
        chk($sformatf("%s_flush_b%0d", nm, k), outq[nexp+k].b, 0);
        chk($sformatf("%s_flush_cyc%0d", nm, k), outq[nexp+k].c, lc + 1 + k);
      end
      chk({nm, "_done_cyc"}, done_cyc, lc + 3);
    end
    chk({nm, "_done_once"}, done_cnt - d0, 1);
  endtask

  localparam logic [63:0] A = 64'hA1A2A3A4A5A6A7A8;
  localparam logic [63:0] B = 64'hB1B2B3B4B5B6B7B8;
  localparam logic [63:0] C = 64'hC1C2C3C4C5C6C7C8;
  localparam logic [63:0] D = 64'hD1D2D3D4D5D6D7D8;

  initial begin
    logic [63:0] p [0:7];
    int d0;
    rstn   = 1'b0;
    width  = '0;
    height = '0;
    start  = 1'b0;
    i_vl   = 1'b0;
    drive_x(64'h0);
    #12;
    chk("rst_rdy", o_rdy, 0);
    chk("rst_ena", o_ena, 0);
    chk("rst_done", o_done, 0);
    chk("rst_x", ox_p, 0);
    chk("rst_b", ob_p, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Basic two-line frame
    vecs.delete();
    vecs.push_back(mk(A, 1, 0, A, 0));
    vecs.push_back(mk(B, 1, 0, B, 0));
    vecs.push_back(mk(C, 1, 0, C, A));
    vecs.push_back(mk(D, 1, 0, D, B));
    applyStimulus("w1h2", 10'd1, 16'd2);

    // Single-group lines: same address every beat
    vecs.delete();
    vecs.push_back(mk({8{8'h11}}, 1, 0, {8{8'h11}}, 0));
    vecs.push_back(mk({8{8'h22}}, 1, 0, {8{8'h22}}, {8{8'h11}}));
    vecs.push_back(mk({8{8'h33}}, 1, 0, {8{8'h33}}, {8{8'h22}}));
    applyStimulus("w0h3", 10'd0, 16'd3);

    // Empty frame
    outq.delete();
    rdy_seen = 1'b0;
    d0 = done_cnt;
    start_frame(10'd5, 16'd0);
    repeat (5) @(negedge clk);
    chk("h0_done_once", done_cnt - d0, 1);
    chk("h0_done_cyc", done_cyc, st_cyc + 2);
    chk("h0_no_ena", outq.size(), 0);
    chk("h0_no_rdy", rdy_seen, 0);

    // Valid toggling every cycle
    for (int k = 0; k < 8; k++) p[k] = {8{8'h40 + 8'(k)}} ^ 64'h0102030405060708;
    vecs.delete();
    for (int k = 0; k < 8; k++) begin
      vecs.push_back(mk(p[k], 1, 0, p[k], (k < 4) ? 64'h0 : p[k-4]));
      vecs.push_back(mk(64'hDEADBEEFDEADBEEF, 0, 0, 0, 0));
    end
    applyStimulus("gaps", 10'd3, 16'd2);

    // Reset in the middle of a frame
    outq.delete();
    start_frame(10'd3, 16'd4);
    for (int k = 0; k < 5; k++) begin
      i_vl = 1'b1;
      drive_x({8{8'h90 + 8'(k)}});
      @(negedge clk);
    end
    i_vl = 1'b0;
    chk("mid_ena_before", o_ena, 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_ena", o_ena, 0);
    chk("mid_rst_rdy", o_rdy, 0);
    chk("mid_rst_x", ox_p, 0);
    chk("mid_rst_b", ob_p, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    outq.delete();
    d0 = done_cnt;
    repeat (4) @(negedge clk);
    chk("mid_no_flush", outq.size(), 0);
    chk("mid_no_done", done_cnt - d0, 0);
    vecs.delete();
    vecs.push_back(mk(A, 1, 0, A, 0));
    vecs.push_back(mk(B, 1, 0, B, 0));
    vecs.push_back(mk(C, 1, 0, C, 0));
    vecs.push_back(mk(D, 1, 0, D, 0));
    applyStimulus("stale", 10'd3, 16'd1);

    // Start pulse with new geometry during RUN must be ignored
    vecs.delete();
    vecs.push_back(mk(A, 1, 0, A, 0));
    vecs.push_back(mk(B, 1, 1, B, 0));
    vecs.push_back(mk(C, 1, 0, C, A));
    vecs.push_back(mk(D, 1, 0, D, B));
    applyStimulus("restart", 10'd1, 16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
